// File: rtl/config_pkg.sv
// Core configuration record; only the physical address width is consumed here.
package config_pkg;

  typedef struct packed {
    int unsigned PLEN;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{PLEN: 32'd34};

endpackage

// File: rtl/mptw_arbiter.sv
// Round-robin arbiter sharing one MPT walker between the load unit and the store buffer.
// One transaction at a time; aborted walks finish the walker handshake silently.
module mptw_arbiter #(
  parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  input  logic                      ld_mptw_enable_i,
  input  logic [CVA6Cfg.PLEN-1:0]   ld_paddr_i,
  output logic                      ld_mptw_valid_o,
  output logic                      ld_mptw_allow_o,
  input  logic                      st_mptw_enable_i,
  input  logic [CVA6Cfg.PLEN-1:0]   st_paddr_i,
  output logic                      st_mptw_valid_o,
  output logic                      st_mptw_allow_o,
  output logic                      walk_req_o,
  input  logic                      walk_gnt_i,
  output logic [CVA6Cfg.PLEN-1:0]   walk_paddr_o,
  output logic                      walk_we_o,
  input  logic                      walk_valid_i,
  input  logic                      walk_allow_i,
  output logic                      busy_o
);

  localparam int unsigned PLEN = CVA6Cfg.PLEN;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;   // 1 = store buffer owns the walker
  logic              last_q, last_d;     // last winner, 1 = store
  logic              allow_q, allow_d;
  logic              abort_q, abort_d;
  logic [PLEN-1:0]   paddr_q, paddr_d;

  logic              ld_valid_q, ld_allow_q;
  logic              st_valid_q, st_allow_q;
  logic              walk_req_q, busy_q;

  logic              win;
  logic              owner_en;
  logic              abort_now;
  logic              resp_d;

  // Next-state, grant and abort tracking
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    allow_d   = allow_q;
    abort_d   = abort_q;
    paddr_d   = paddr_q;
    win       = 1'b0;
    owner_en  = owner_q ? st_mptw_enable_i : ld_mptw_enable_i;
    // Store-owned walks survive a flush: committed stores are non-speculative.
    abort_now = abort_q | ~owner_en | (flush_i & ~owner_q);

    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (ld_mptw_enable_i | st_mptw_enable_i) begin
          win     = (ld_mptw_enable_i & st_mptw_enable_i) ? ~last_q : st_mptw_enable_i;
          owner_d = win;
          last_d  = win;
          paddr_d = win ? st_paddr_i : ld_paddr_i;
          state_d = REQ;
        end
      end
      REQ: begin
        abort_d = abort_now;
        if (walk_gnt_i) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        abort_d = abort_now;
        if (walk_valid_i) begin
          allow_d = walk_allow_i & ~abort_now;
          abort_d = 1'b0;
          state_d = abort_now ? IDLE : RESP;
        end
      end
      RESP: begin
        abort_d = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign resp_d = (state_d == RESP);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b0;
      allow_q    <= 1'b0;
      abort_q    <= 1'b0;
      paddr_q    <= '0;
      ld_valid_q <= 1'b0;
      ld_allow_q <= 1'b0;
      st_valid_q <= 1'b0;
      st_allow_q <= 1'b0;
      walk_req_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      allow_q    <= allow_d;
      abort_q    <= abort_d;
      paddr_q    <= paddr_d;
      ld_valid_q <= resp_d & ~owner_d;
      ld_allow_q <= resp_d & ~owner_d & allow_d;
      st_valid_q <= resp_d & owner_d;
      st_allow_q <= resp_d & owner_d & allow_d;
      walk_req_q <= (state_d == REQ);
      busy_q     <= (state_d != IDLE);
    end
  end

  assign ld_mptw_valid_o = ld_valid_q;
  assign ld_mptw_allow_o = ld_allow_q;
  assign st_mptw_valid_o = st_valid_q;
  assign st_mptw_allow_o = st_allow_q;
  assign walk_req_o      = walk_req_q;
  assign walk_paddr_o    = paddr_q;
  assign walk_we_o       = owner_q;
  assign busy_o          = busy_q;

endmodule
